data_memory: RTL and testbench

Word-addressed data memory that answers the load/store traffic issued by the datapath. It accepts one request at a time through a req/ready handshake and stalls for a programmable number of wait states. For writes it stores `word_w` at `word_a`; for reads it returns `word_r`. A one-cycle `done` pulse marks completion so the control unit can advance.

---
 rtl/data_memory.sv | 120 ++++++++++++
 tb/tb_data_memory.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// Word-addressed data memory with a req/ready handshake, programmable wait states and a one-cycle done pulse.
// Optional even-parity protection of each stored word is enabled by defining DMEM_PARITY_EN.
module data_memory #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [9:0]  word_a,
    input  logic [15:0] word_w,
    output logic [15:0] word_r,
    output logic        ready,
    output logic        done,
    output logic        parity_err
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef DMEM_PARITY_EN
    localparam int MW = 17;
`else
    localparam int MW = 16;
`endif

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_reg, state_next;
    logic [3:0]      cnt_reg, cnt_next;
    logic [AW-1:0]   addr_reg;
    logic [15:0]     data_reg;
    logic            we_reg;
    logic            accept, access;
    logic [MW-1:0]   mem [DEPTH];
    logic [MW-1:0]   wr_entry;

    // Upper address bits alias modulo DEPTH; only the low AW bits index the array.
    logic unused_addr_bits;
    assign unused_addr_bits = ^word_a;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ready      = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        access     = 1'b0;
        case (state_reg)
            IDLE: begin
                ready = 1'b1;
                if (req) begin
                    accept     = 1'b1;
                    cnt_next   = 4'(WAIT_STATES);
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (cnt_reg != 4'd0) begin
                    cnt_next = cnt_reg - 4'd1;
                end else begin
                    access     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef DMEM_PARITY_EN
    assign wr_entry = {^data_reg, data_reg};
`else
    assign wr_entry = data_reg;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= 4'd0;
            addr_reg   <= '0;
            data_reg   <= 16'h0000;
            we_reg     <= 1'b0;
            word_r     <= 16'h0000;
`ifdef DMEM_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                addr_reg   <= word_a[AW-1:0];
                data_reg   <= word_w;
                we_reg     <= we;
`ifdef DMEM_PARITY_EN
                parity_err <= 1'b0;
`endif
            end
            if (access && !we_reg) begin
                word_r     <= mem[addr_reg][15:0];
`ifdef DMEM_PARITY_EN
                // Stored bit makes the 17-bit entry even; any odd entry is corrupt.
                parity_err <= ^mem[addr_reg];
`endif
            end
        end
    end

`ifndef DMEM_PARITY_EN
    assign parity_err = 1'b0;
`endif

    // Array is never reset; gating with reset keeps an aborted write from committing.
    always_ff @(posedge clock) begin
        if (reset && access && we_reg) begin
            mem[addr_reg] <= wr_entry;
        end
    end
endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: three instances (WS=2, WS=0, DEPTH=256) driven by directed vectors,
// checked every cycle against a timestamp-based behavioural model plus literal expectations.
module tb_data_memory;
    localparam int N = 3;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst_n      [N];
    logic        req        [N];
    logic        we         [N];
    logic [9:0]  word_a     [N];
    logic [15:0] word_w     [N];
    logic [15:0] word_r     [N];
    logic        ready      [N];
    logic        done       [N];
    logic        parity_err [N];

    int checks = 0;
    int errors = 0;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_dut
            data_memory #(
                .DEPTH      ((gi == 2) ? 256 : 1024),
                .WAIT_STATES((gi == 1) ? 0 : 2)
            ) u_dut (
                .clock     (clock),
                .reset     (rst_n[gi]),
                .req       (req[gi]),
                .we        (we[gi]),
                .word_a    (word_a[gi]),
                .word_w    (word_w[gi]),
                .word_r    (word_r[gi]),
                .ready     (ready[gi]),
                .done      (done[gi]),
                .parity_err(parity_err[gi])
            );
        end
    endgenerate

    function automatic int ws_of(input int i);
        return (i == 1) ? 0 : 2;
    endfunction

    function automatic int depth_of(input int i);
        return (i == 2) ? 256 : 1024;
    endfunction

    task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got 0x%0h, expected 0x%0h", name, i, act, exp);
        end
    endtask

    // Behavioural model: each request is a timestamped transaction (accept edge, access edge).
    int          edge_n = 0;
    bit          m_busy     [N];
    int          m_acc      [N];
    int          m_ready_at [N];
    bit          m_ready    [N];
    bit          m_done     [N];
    int          m_addr     [N];
    logic [15:0] m_data     [N];
    bit          m_we       [N];
    logic [15:0] m_wr       [N];
    bit          m_wr_known [N];
    logic [15:0] m_mem      [N][1024];
    bit          m_val      [N][1024];

    initial begin
        bit prev;
        for (int i = 0; i < N; i++) begin
            m_busy[i] = 0; m_ready[i] = 1; m_ready_at[i] = 0; m_done[i] = 0;
            m_wr[i] = 16'h0000; m_wr_known[i] = 1;
            for (int a = 0; a < 1024; a++) m_val[i][a] = 0;
        end
        forever begin
            @(posedge clock);
            edge_n++;
            for (int i = 0; i < N; i++) begin
                if (!rst_n[i]) begin
                    m_busy[i] = 0; m_done[i] = 0; m_ready[i] = 1; m_ready_at[i] = 0;
                    m_wr[i] = 16'h0000; m_wr_known[i] = 1;
                end else begin
                    prev      = m_ready[i];
                    m_done[i] = 0;
                    if (m_busy[i] && edge_n == m_acc[i]) begin
                        if (m_we[i]) begin
                            m_mem[i][m_addr[i]] = m_data[i];
                            m_val[i][m_addr[i]] = 1;
                        end else if (m_val[i][m_addr[i]]) begin
                            m_wr[i] = m_mem[i][m_addr[i]];
                            m_wr_known[i] = 1;
                        end else begin
                            m_wr_known[i] = 0;
                        end
                        m_busy[i] = 0; m_done[i] = 1; m_ready_at[i] = edge_n + 1;
                    end else if (prev && req[i]) begin
                        m_busy[i] = 1;
                        m_acc[i]  = edge_n + ws_of(i) + 1;
                        m_addr[i] = int'(word_a[i]) % depth_of(i);
                        m_data[i] = word_w[i];
                        m_we[i]   = we[i];
                    end
                    m_ready[i] = !m_busy[i] && edge_n >= m_ready_at[i];
                end
            end
            #1;
            for (int i = 0; i < N; i++) begin
                check("ready", i, 32'(ready[i]), 32'(m_ready[i]));
                check("done", i, 32'(done[i]), 32'(m_done[i]));
                if (m_wr_known[i]) begin
                    check("word_r", i, 32'(word_r[i]), 32'(m_wr[i]));
                    check("parity_err", i, 32'(parity_err[i]), 32'd0);
                end
            end
        end
    end

    // Issues one request, waits for acceptance, then counts edges from accept to done.
    task automatic access_op(input int i, input bit w, input logic [9:0] a, input logic [15:0] d, output int lat);
        int n;
        @(negedge clock);
        req[i] = 1; we[i] = w; word_a[i] = a; word_w[i] = d;
        n = 0;
        while (!ready[i] && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) begin
            check("accept_timeout", i, 32'd1, 32'd0);
            req[i] = 0;
            lat = -1;
            return;
        end
        @(posedge clock);
        @(negedge clock);
        req[i] = 0; we[i] = ~w; word_a[i] = 10'h3AB; word_w[i] = 16'hDEAD;
        for (lat = 1; lat < 50; lat++) begin
            @(posedge clock);
            #1;
            if (done[i]) break;
        end
        if (lat >= 50) check("done_timeout", i, 32'd1, 32'd0);
    endtask

    task automatic wait_ready(input int i);
        int n = 0;
        while (!ready[i] && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) check("ready_timeout", i, 32'd1, 32'd0);
    endtask

    initial begin
        int lat, last, n;
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, last, n;
        for (int i = 0; i < N; i++) begin
            rst_n[i] = 0; req[i] = 0; we[i] = 0; word_a[i] = '0; word_w[i] = '0;
        end
        repeat (3) @(posedge clock);
        #1;
        for (int i = 0; i < N; i++) begin
            check("rst_ready", i, 32'(ready[i]), 32'd1);
            check("rst_done", i, 32'(done[i]), 32'd0);
            check("rst_word_r", i, 32'(word_r[i]), 32'h0000);
            check("rst_parity", i, 32'(parity_err[i]), 32'd0);
        end
        @(negedge clock);
        for (int i = 0; i < N; i++) rst_n[i] = 1;

        // Instance 0: WAIT_STATES=2
        access_op(0, 1, 10'h010, 16'h1234, lat);
        check("wr_latency_ws2", 0, 32'(lat), 32'd3);
        @(negedge clock);
        wait_ready(0);
        req[0] = 1; we[0] = 1; word_a[0] = 10'h010; word_w[0] = 16'h5678;
        @(posedge clock);
        @(negedge clock);
        req[0] = 0; rst_n[0] = 0;
        @(posedge clock);
        #1;
        check("abort_ready", 0, 32'(ready[0]), 32'd1);
        check("abort_done", 0, 32'(done[0]), 32'd0);
        check("abort_word_r", 0, 32'(word_r[0]), 32'h0000);
        @(negedge clock);
        rst_n[0] = 1;
        access_op(0, 0, 10'h010, 16'h0000, lat);
        check("abort_no_commit", 0, 32'(word_r[0]), 32'h1234);

        access_op(0, 1, 10'h005, 16'hBEEF, lat);
        check("wr_latency_ws2", 0, 32'(lat), 32'd3);
        @(posedge clock);
        #1;
        check("ready_after_k4", 0, 32'(ready[0]), 32'd1);
        access_op(0, 0, 10'h005, 16'h0000, lat);
        check("rd_latency_ws2", 0, 32'(lat), 32'd3);
        check("rd_beef", 0, 32'(word_r[0]), 32'hBEEF);

        // Held request with inputs changing during BUSY: only the first write lands.
        access_op(0, 1, 10'h006, 16'h0666, lat);
        @(negedge clock);
        wait_ready(0);
        req[0] = 1; we[0] = 1; word_a[0] = 10'h005; word_w[0] = 16'h1111;
        @(posedge clock);
        @(negedge clock);
        word_a[0] = 10'h006; word_w[0] = 16'h2222;
        n = 0;
        while (!done[0] && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("held_done_seen", 0, 32'(done[0]), 32'd1);
        @(negedge clock);
        req[0] = 0;
        check("write_keeps_word_r", 0, 32'(word_r[0]), 32'hBEEF);
        access_op(0, 0, 10'h006, 16'h0000, lat);
        check("addr_006_untouched", 0, 32'(word_r[0]), 32'h0666);
        access_op(0, 0, 10'h005, 16'h0000, lat);
        check("addr_005_first_only", 0, 32'(word_r[0]), 32'h1111);

        // Parity patterns
        access_op(0, 1, 10'h040, 16'hFFFF, lat);
        access_op(0, 1, 10'h041, 16'h0001, lat);
        access_op(0, 0, 10'h040, 16'h0000, lat);
        check("par_ffff_data", 0, 32'(word_r[0]), 32'hFFFF);
        check("par_ffff_err", 0, 32'(parity_err[0]), 32'd0);
        access_op(0, 0, 10'h041, 16'h0000, lat);
        check("par_0001_data", 0, 32'(word_r[0]), 32'h0001);
        check("par_0001_err", 0, 32'(parity_err[0]), 32'd0);

        // Instance 1: WAIT_STATES=0
        access_op(1, 1, 10'h005, 16'hBEEF, lat);
        check("wr_latency_ws0", 1, 32'(lat), 32'd1);
        access_op(1, 0, 10'h005, 16'h0000, lat);
        check("rd_latency_ws0", 1, 32'(lat), 32'd1);
        check("rd_beef_ws0", 1, 32'(word_r[1]), 32'hBEEF);
        @(negedge clock);
        wait_ready(1);
        req[1] = 1; we[1] = 0; word_a[1] = 10'h005;
        last = -1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clock);
            #1;
            if (done[1]) begin
                if (last >= 0) check("b2b_period", 1, 32'(c - last), 32'd3);
                last = c;
            end
        end
        @(negedge clock);
        req[1] = 0;
        wait_ready(1);
        // Reset coincident with the accept edge drops the request.
        req[1] = 1; we[1] = 1; word_a[1] = 10'h005; word_w[1] = 16'hDEAD; rst_n[1] = 0;
        @(posedge clock);
        @(negedge clock);
        req[1] = 0; rst_n[1] = 1;
        access_op(1, 0, 10'h005, 16'h0000, lat);
        check("rst_at_accept_dropped", 1, 32'(word_r[1]), 32'hBEEF);

        // Instance 2: DEPTH=256 aliasing
        access_op(2, 1, 10'h3FF, 16'h00AA, lat);
        access_op(2, 0, 10'h0FF, 16'h0000, lat);
        check("alias_0ff", 2, 32'(word_r[2]), 32'h00AA);

        repeat (4) @(posedge clock);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
